// File: rtl/mpi_coll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : mpi_coll_pkg                                                  |
// | Description: Flit field layout, reduction op codes and the reduction       |
// |              table entry type shared by the collective-offload blocks.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package mpi_coll_pkg;

  // Bit positions inside a 73-bit network flit (children field only on local flits)
  localparam int c_pos_payload = 0;
  localparam int c_pos_op      = 32;
  localparam int c_pos_alg     = 36;
  localparam int c_pos_tag     = 38;
  localparam int c_pos_ctx     = 46;
  localparam int c_pos_src     = 54;
  localparam int c_pos_dst     = 63;
  localparam int c_pos_valid   = 72;
  localparam int c_pos_chd     = 73;

  // Field widths
  localparam int c_w_payload = 32;
  localparam int c_w_op      = 4;
  localparam int c_w_alg     = 2;
  localparam int c_w_tag     = 8;
  localparam int c_w_ctx     = 8;
  localparam int c_w_coord   = 9;
  localparam int c_w_chd     = 3;

  // Reduction operators; any other code folds as a sum
  localparam logic [c_w_op-1:0] c_op_sum = 4'd0;
  localparam logic [c_w_op-1:0] c_op_max = 4'd1;
  localparam logic [c_w_op-1:0] c_op_min = 4'd2;
  localparam logic [c_w_op-1:0] c_op_and = 4'd3;
  localparam logic [c_w_op-1:0] c_op_or  = 4'd4;
  localparam logic [c_w_op-1:0] c_op_xor = 4'd5;

  // One in-flight reduction
  typedef struct packed {
    logic                   busy;
    logic [c_w_ctx-1:0]     ctx;
    logic [c_w_tag-1:0]     tag;
    logic [c_w_coord-1:0]   dst;
    logic [c_w_op-1:0]      op;
    logic [c_w_alg-1:0]     alg;
    logic [c_w_payload-1:0] acc;
    logic [c_w_chd-1:0]     nchild;
    logic [c_w_chd-1:0]     arrived;
    logic                   loc_seen;
    logic                   done;
  } entry_t;

endpackage : mpi_coll_pkg
`default_nettype wire

// File: rtl/reduce_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reduce_alu                                                    |
// | Description: Combinational fold f(a,b,op) for unsigned reductions.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reduce_alu
  import mpi_coll_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [c_w_op-1:0] i_op,
  output logic [WIDTH-1:0]  o_res
);

  // Select the fold; unknown op codes fall back to a wrapping sum
  always_comb begin
    o_res = i_a + i_b;
    case (i_op)
      c_op_max: o_res = (i_a > i_b) ? i_a : i_b;
      c_op_min: o_res = (i_a < i_b) ? i_a : i_b;
      c_op_and: o_res = i_a & i_b;
      c_op_or:  o_res = i_a | i_b;
      c_op_xor: o_res = i_a ^ i_b;
      default:  o_res = i_a + i_b;
    endcase
  end

endmodule : reduce_alu
`default_nettype wire

// File: rtl/reduce_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : reduce_table                                                  |
// | Description: Reduction combine stage. Folds the local contribution and the |
// |              child contributions per {ctx,tag} and emits one flit upward.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module reduce_table
  import mpi_coll_pkg::*;
#(
  parameter int         FLIT_WIDTH     = 73,
  parameter int         CHILDREN_WIDTH = 3,
  parameter int         PAYLOAD_WIDTH  = 32,
  parameter int         TABLE_DEPTH    = 4,
  parameter logic [2:0] RANK_X         = 3'd0,
  parameter logic [2:0] RANK_Y         = 3'd0,
  parameter logic [2:0] RANK_Z         = 3'd0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FLIT_WIDTH+CHILDREN_WIDTH-1:0] loc_flit,
  output logic                               loc_ready,
  input  logic [FLIT_WIDTH-1:0]              chd_flit,
  output logic                               chd_ready,
  output logic [FLIT_WIDTH-1:0]              out_flit,
  input  logic                               out_ready,
  output logic                               table_full
);

  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

  entry_t                  r_tab [TABLE_DEPTH];
  logic [FLIT_WIDTH-1:0]   r_out;

  logic                    w_loc_v;
  logic                    w_chd_v;
  logic                    w_sel_chd;
  logic [c_w_ctx-1:0]      w_ctx;
  logic [c_w_tag-1:0]      w_tag;
  logic [c_w_coord-1:0]    w_dst;
  logic [c_w_op-1:0]       w_op;
  logic [c_w_alg-1:0]      w_alg;
  logic [c_w_payload-1:0]  w_payload;
  logic [c_w_chd-1:0]      w_children;

  logic                    w_hit;
  logic [IDX_W-1:0]        w_hit_idx;
  logic                    w_free;
  logic [IDX_W-1:0]        w_free_idx;
  logic                    w_done_any;
  logic [IDX_W-1:0]        w_done_idx;
  logic [IDX_W-1:0]        w_tgt_idx;
  logic                    w_update;
  logic                    w_out_load;
  logic                    w_full;

  logic [c_w_op-1:0]       w_alu_op;
  logic [PAYLOAD_WIDTH-1:0] w_alu_res;
  entry_t                  w_new;
  logic [FLIT_WIDTH-1:0]   w_out_next;

  // The source coordinates of incoming flits are replaced by this node's rank
  logic w_unused_src;
  assign w_unused_src = ^{loc_flit[c_pos_src +: c_w_coord], chd_flit[c_pos_src +: c_w_coord]};

  // Child input wins arbitration; only one flit's fields feed the update path
  assign w_loc_v    = loc_flit[c_pos_valid];
  assign w_chd_v    = chd_flit[c_pos_valid];
  assign w_sel_chd  = w_chd_v;
  assign w_ctx      = w_sel_chd ? chd_flit[c_pos_ctx +: c_w_ctx]         : loc_flit[c_pos_ctx +: c_w_ctx];
  assign w_tag      = w_sel_chd ? chd_flit[c_pos_tag +: c_w_tag]         : loc_flit[c_pos_tag +: c_w_tag];
  assign w_dst      = w_sel_chd ? chd_flit[c_pos_dst +: c_w_coord]       : loc_flit[c_pos_dst +: c_w_coord];
  assign w_op       = w_sel_chd ? chd_flit[c_pos_op +: c_w_op]           : loc_flit[c_pos_op +: c_w_op];
  assign w_alg      = w_sel_chd ? chd_flit[c_pos_alg +: c_w_alg]         : loc_flit[c_pos_alg +: c_w_alg];
  assign w_payload  = w_sel_chd ? chd_flit[c_pos_payload +: c_w_payload] : loc_flit[c_pos_payload +: c_w_payload];
  assign w_children = loc_flit[c_pos_chd +: c_w_chd];

  // Priority lookups: descending scan so the lowest matching index is kept
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_done_any = 1'b0;
    w_done_idx = '0;
    w_full     = 1'b1;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (r_tab[i].busy && !r_tab[i].done && r_tab[i].ctx == w_ctx && r_tab[i].tag == w_tag) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!r_tab[i].busy) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
        w_full     = 1'b0;
      end
      if (r_tab[i].busy && r_tab[i].done) begin
        w_done_any = 1'b1;
        w_done_idx = IDX_W'(i);
      end
    end
  end

  // A flit stalls only when it misses and there is no entry left to allocate
  assign chd_ready  = !w_chd_v || w_hit || w_free;
  assign loc_ready  = !w_chd_v && (!w_loc_v || w_hit || w_free);
  assign w_update   = w_chd_v ? chd_ready : (w_loc_v && loc_ready);
  assign w_tgt_idx  = w_hit ? w_hit_idx : w_free_idx;
  assign table_full = w_full;

  // The local flit carries the authoritative op; children use what the entry holds
  assign w_alu_op = w_sel_chd ? r_tab[w_hit_idx].op : w_op;

  reduce_alu #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_alu (
    .i_a   (r_tab[w_hit_idx].acc),
    .i_b   (w_payload),
    .i_op  (w_alu_op),
    .o_res (w_alu_res)
  );

  // Post-update contents of the target entry, including the completion flag
  always_comb begin
    w_new = r_tab[w_tgt_idx];
    if (w_sel_chd) begin
      if (w_hit) begin
        w_new.acc     = w_alu_res;
        w_new.arrived = (r_tab[w_hit_idx].arrived == 3'd7) ? 3'd7 : r_tab[w_hit_idx].arrived + 3'd1;
      end else begin
        w_new          = '0;
        w_new.busy     = 1'b1;
        w_new.ctx      = w_ctx;
        w_new.tag      = w_tag;
        w_new.dst      = w_dst;
        w_new.op       = w_op;
        w_new.alg      = w_alg;
        w_new.acc      = w_payload;
        w_new.arrived  = 3'd1;
      end
    end else begin
      if (w_hit) begin
        w_new.acc = w_alu_res;
      end else begin
        w_new         = '0;
        w_new.busy    = 1'b1;
        w_new.ctx     = w_ctx;
        w_new.tag     = w_tag;
        w_new.acc     = w_payload;
        w_new.arrived = 3'd0;
      end
      w_new.loc_seen = 1'b1;
      w_new.nchild   = w_children;
      w_new.dst      = w_dst;
      w_new.op       = w_op;
      w_new.alg      = w_alg;
    end
    w_new.done = w_new.loc_seen && (w_new.arrived == w_new.nchild);
  end

  // Outgoing flit assembled from the lowest-index completed entry
  always_comb begin
    w_out_next                                = '0;
    w_out_next[c_pos_valid]                   = 1'b1;
    w_out_next[c_pos_dst +: c_w_coord]        = r_tab[w_done_idx].dst;
    w_out_next[c_pos_src +: c_w_coord]        = {RANK_Z, RANK_Y, RANK_X};
    w_out_next[c_pos_ctx +: c_w_ctx]          = r_tab[w_done_idx].ctx;
    w_out_next[c_pos_tag +: c_w_tag]          = r_tab[w_done_idx].tag;
    w_out_next[c_pos_alg +: c_w_alg]          = r_tab[w_done_idx].alg;
    w_out_next[c_pos_op +: c_w_op]            = r_tab[w_done_idx].op;
    w_out_next[c_pos_payload +: c_w_payload]  = r_tab[w_done_idx].acc;
  end

  assign w_out_load = !r_out[c_pos_valid] || out_ready;

  // Table update and output register; a completed entry is freed as it is emitted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        r_tab[i] <= '0;
      end
      r_out <= '0;
    end else begin
      if (w_update) begin
        r_tab[w_tgt_idx] <= w_new;
      end
      if (w_out_load) begin
        if (w_done_any) begin
          r_out             <= w_out_next;
          r_tab[w_done_idx] <= '0;
        end else begin
          r_out <= '0;
        end
      end
    end
  end

  assign out_flit = r_out;

endmodule : reduce_table
`default_nettype wire

// File: tb/tb_reduce_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_reduce_table                                               |
// | Description: Directed self-checking bench for reduce_table.                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_reduce_table;

  localparam logic [2:0] RX = 3'd1;
  localparam logic [2:0] RY = 3'd2;
  localparam logic [2:0] RZ = 3'd3;
  localparam logic [8:0] RANK_SRC = {RZ, RY, RX};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [75:0] loc_flit = '0;
  logic        loc_ready;
  logic [72:0] chd_flit = '0;
  logic        chd_ready;
  logic [72:0] out_flit;
  logic        out_ready = 1'b1;
  logic        table_full;

  int checks   = 0;
  int failures = 0;
  logic [72:0] q[$];

  always #5 clk = ~clk;

  reduce_table #(
    .FLIT_WIDTH     (73),
    .CHILDREN_WIDTH (3),
    .PAYLOAD_WIDTH  (32),
    .TABLE_DEPTH    (4),
    .RANK_X         (RX),
    .RANK_Y         (RY),
    .RANK_Z         (RZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .loc_flit   (loc_flit),
    .loc_ready  (loc_ready),
    .chd_flit   (chd_flit),
    .chd_ready  (chd_ready),
    .out_flit   (out_flit),
    .out_ready  (out_ready),
    .table_full (table_full)
  );

  // Record every flit that will be taken by the parent at the next edge
  always @(negedge clk) begin
    if (!rst && out_flit[72] && out_ready) q.push_back(out_flit);
  end

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [72:0] mk(input logic [8:0] dst, input logic [8:0] src,
                                     input logic [7:0] ctx, input logic [7:0] tag,
                                     input logic [1:0] alg, input logic [3:0] op,
                                     input logic [31:0] pl);
    return {1'b1, dst, src, ctx, tag, alg, op, pl};
  endfunction

  // Drivers assume they are called 1 time unit after a rising edge
  task automatic send_chd(input logic [72:0] f);
    int n = 0;
    chd_flit = f;
    @(negedge clk);
    while (!chd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("chd_accept", 76'(chd_ready), 76'(1));
    @(posedge clk);
    #1 chd_flit = '0;
  endtask

  task automatic send_loc(input logic [75:0] f);
    int n = 0;
    loc_flit = f;
    @(negedge clk);
    while (!loc_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("loc_accept", 76'(loc_ready), 76'(1));
    @(posedge clk);
    #1 loc_flit = '0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (q.size() < n && k < 30) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("out_count", 76'(q.size()), 76'(n));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    int          nchd;
    logic [31:0] chd [3];
    logic [31:0] locp;
    bit          loc_first;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] op, input int n,
                               input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                               input logic [31:0] lp, input bit lf, input logic [31:0] ex);
    vec_t v;
    v.op = op; v.nchd = n; v.chd[0] = c0; v.chd[1] = c1; v.chd[2] = c2;
    v.locp = lp; v.loc_first = lf; v.exp = ex;
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [72:0] exp_f;
    logic [72:0] held;
    logic [8:0]  d;
    logic [7:0]  cx;
    logic [7:0]  tg;
    logic [1:0]  al;
    int          n;

    vecs.push_back(mkv(4'd0, 3, 32'd2, 32'd3, 32'd4, 32'd1, 1'b1, 32'd10));
    vecs.push_back(mkv(4'd1, 2, 32'd5, 32'd9, 32'd0, 32'd6, 1'b0, 32'd9));
    vecs.push_back(mkv(4'd2, 2, 32'd7, 32'd30, 32'd0, 32'd20, 1'b1, 32'd7));
    vecs.push_back(mkv(4'd3, 1, 32'hFF00_FF0F, 32'd0, 32'd0, 32'hF0F0_FFFF, 1'b1, 32'hF000_FF0F));
    vecs.push_back(mkv(4'd4, 2, 32'h10, 32'h100, 32'd0, 32'h1, 1'b0, 32'h111));
    vecs.push_back(mkv(4'd5, 2, 32'h0F, 32'hF0, 32'd0, 32'hFF, 1'b1, 32'h0));
    vecs.push_back(mkv(4'd0, 1, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd1));
    vecs.push_back(mkv(4'd9, 2, 32'd3, 32'd4, 32'd0, 32'd5, 1'b0, 32'd12));
    vecs.push_back(mkv(4'd1, 0, 32'd0, 32'd0, 32'd0, 32'h42, 1'b1, 32'h42));
    vecs.push_back(mkv(4'd2, 3, 32'd100, 32'd50, 32'd75, 32'd60, 1'b0, 32'd50));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_flit", 76'(out_flit), 76'(0));
    check("rst_loc_ready", 76'(loc_ready), 76'(1));
    check("rst_chd_ready", 76'(chd_ready), 76'(1));
    check("rst_table_full", 76'(table_full), 76'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Leaf with latency check
    q.delete();
    d = 9'b001_001_001;
    loc_flit = {3'd0, mk(d, 9'h000, 8'd1, 8'd2, 2'd0, 4'd0, 32'd7)};
    @(negedge clk);
    check("leaf_loc_ready", 76'(loc_ready), 76'(1));
    @(posedge clk);
    #1 loc_flit = '0;
    check("leaf_not_early", 76'(out_flit[72]), 76'(0));
    @(posedge clk);
    #1;
    check("leaf_out", 76'(out_flit), 76'(mk(d, RANK_SRC, 8'd1, 8'd2, 2'd0, 4'd0, 32'd7)));
    wait_out(1);

    // Table-driven reductions
    foreach (vecs[i]) begin
      q.delete();
      d  = 9'(i + 8);
      cx = 8'(i + 16);
      tg = 8'(i + 32);
      al = 2'(i % 4);
      if (vecs[i].loc_first)
        send_loc({3'(vecs[i].nchd), mk(d, 9'h0AA, cx, tg, al, vecs[i].op, vecs[i].locp)});
      for (int j = 0; j < vecs[i].nchd; j++)
        send_chd(mk(9'h155, 9'h1FF, cx, tg, 2'd3, vecs[i].op, vecs[i].chd[j]));
      if (!vecs[i].loc_first)
        send_loc({3'(vecs[i].nchd), mk(d, 9'h0AA, cx, tg, al, vecs[i].op, vecs[i].locp)});
      wait_out(1);
      exp_f = mk(d, RANK_SRC, cx, tg, al, vecs[i].op, vecs[i].exp);
      if (q.size() > 0) check($sformatf("vec%0d_out", i), 76'(q[0]), 76'(exp_f));
      check($sformatf("vec%0d_empty", i), 76'({table_full, loc_ready, chd_ready}), 76'(3'b011));
    end

    // Full table and output backpressure
    q.delete();
    out_ready = 1'b0;
    d = 9'h0C3;
    for (int k = 0; k < 4; k++)
      send_loc({3'd1, mk(d, 9'h0, 8'(8'h60 + k), 8'd1, 2'd0, 4'd0, 32'(k + 1))});
    check("full_flag", 76'(table_full), 76'(1));
    loc_flit = {3'd0, mk(d, 9'h0, 8'h64, 8'd1, 2'd0, 4'd0, 32'h99)};
    @(negedge clk);
    check("full_stall", 76'(loc_ready), 76'(0));
    @(negedge clk);
    check("full_stall2", 76'(loc_ready), 76'(0));
    @(posedge clk);
    #1;
    send_chd(mk(9'h155, 9'h1FF, 8'h60, 8'd1, 2'd0, 4'd0, 32'd10));
    n = 0;
    @(negedge clk);
    while (!loc_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("full_loc_accept", 76'(loc_ready), 76'(1));
    @(posedge clk);
    #1 loc_flit = '0;
    held = mk(d, RANK_SRC, 8'h60, 8'd1, 2'd0, 4'd0, 32'd11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", k), 76'(out_flit), 76'(held));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 1; k < 4; k++)
      send_chd(mk(9'h155, 9'h1FF, 8'(8'h60 + k), 8'd1, 2'd0, 4'd0, 32'd10));
    wait_out(5);
    if (q.size() > 0) check("bp_out0", 76'(q[0]), 76'(held));
    if (q.size() > 1) check("bp_out1", 76'(q[1]), 76'(mk(d, RANK_SRC, 8'h64, 8'd1, 2'd0, 4'd0, 32'h99)));
    if (q.size() > 2) check("bp_out2", 76'(q[2]), 76'(mk(d, RANK_SRC, 8'h61, 8'd1, 2'd0, 4'd0, 32'd12)));
    if (q.size() > 3) check("bp_out3", 76'(q[3]), 76'(mk(d, RANK_SRC, 8'h62, 8'd1, 2'd0, 4'd0, 32'd13)));
    if (q.size() > 4) check("bp_out4", 76'(q[4]), 76'(mk(d, RANK_SRC, 8'h63, 8'd1, 2'd0, 4'd0, 32'd14)));
    check("bp_empty", 76'(table_full), 76'(0));

    // Same key on both inputs in the same cycle
    q.delete();
    d = 9'h011;
    loc_flit = {3'd1, mk(d, 9'h0, 8'h50, 8'h05, 2'd1, 4'd0, 32'd10)};
    chd_flit = mk(9'h155, 9'h1FF, 8'h50, 8'h05, 2'd0, 4'd0, 32'd5);
    @(negedge clk);
    check("coll_chd_ready", 76'(chd_ready), 76'(1));
    check("coll_loc_ready", 76'(loc_ready), 76'(0));
    @(posedge clk);
    #1 chd_flit = '0;
    @(negedge clk);
    check("coll_loc_next", 76'(loc_ready), 76'(1));
    @(posedge clk);
    #1 loc_flit = '0;
    wait_out(1);
    if (q.size() > 0) check("coll_out", 76'(q[0]), 76'(mk(d, RANK_SRC, 8'h50, 8'h05, 2'd1, 4'd0, 32'd15)));

    // Asynchronous reset in the middle of a reduction
    q.delete();
    out_ready = 1'b0;
    d = 9'h022;
    send_loc({3'd0, mk(d, 9'h0, 8'h70, 8'd1, 2'd0, 4'd0, 32'd1)});
    send_loc({3'd2, mk(d, 9'h0, 8'h71, 8'd1, 2'd0, 4'd0, 32'd100)});
    check("rst_pre_valid", 76'(out_flit[72]), 76'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_async_out", 76'(out_flit), 76'(0));
    check("rst_async_full", 76'(table_full), 76'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_chd(mk(9'h155, 9'h1FF, 8'h71, 8'd1, 2'd0, 4'd0, 32'd3));
    send_loc({3'd1, mk(d, 9'h0, 8'h71, 8'd1, 2'd0, 4'd0, 32'd4)});
    wait_out(1);
    if (q.size() > 0) check("rst_fresh_out", 76'(q[0]), 76'(mk(d, RANK_SRC, 8'h71, 8'd1, 2'd0, 4'd0, 32'd7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reduce_table
`default_nettype wire
